// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared constants, the converter state type and small helpers for the
// 3-digit 7-segment scan stage (seg7_scan_timer and bin2bcd_seq).
// -----------------------------------------------------------------------------
package seg7_pkg;

    // Phase bus encodings seen by the downstream digit switcher
    localparam logic [1:0] PH_D1 = 2'b00;   // ones digit
    localparam logic [1:0] PH_D2 = 2'b01;   // tens digit
    localparam logic [1:0] PH_D3 = 2'b10;   // hundreds digit

    localparam int         NUM_DIGITS = 3;
    localparam int         BIN_W      = 10;
    localparam int         BCD_W      = 4 * NUM_DIGITS;
    localparam logic [9:0] MAX_VALUE  = 10'd999;

    // Double-dabble converter states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_e;

    // Scan order 00 -> 01 -> 10 -> 00; the unused code 11 recovers to 00
    function automatic logic [1:0] next_phase(input logic [1:0] ph);
        logic [1:0] nxt;
        case (ph)
            PH_D1:   nxt = PH_D2;
            PH_D2:   nxt = PH_D3;
            default: nxt = PH_D1;
        endcase
        return nxt;
    endfunction

    // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift
    function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] res;
        res = bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (res[i*4 +: 4] >= 4'd5) begin
                res[i*4 +: 4] = res[i*4 +: 4] + 4'd3;
            end else begin
                res[i*4 +: 4] = res[i*4 +: 4];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential 10-bit binary to 3-digit BCD converter (double dabble), one
// iteration per clock. A start in IDLE captures the operand; ten SHIFT cycles
// follow, then one DONE cycle before returning to IDLE.
//
// Ports:
//   i_clk    clock
//   i_rst    synchronous active-high reset, aborts any conversion
//   i_start  capture i_bin and start (honoured only in IDLE)
//   i_bin    binary operand (caller limits it to 0..999)
//   o_busy   high in SHIFT and DONE
//   o_done   one-cycle pulse on the cycle whose edge applies the last
//            iteration; o_bcd is valid on that same cycle
//   o_bcd    {hundreds, tens, ones}
// -----------------------------------------------------------------------------
module bin2bcd_seq
    import seg7_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [BIN_W-1:0] i_bin,
    output logic             o_busy,
    output logic             o_done,
    output logic [BCD_W-1:0] o_bcd
);

    localparam int         SH_W      = BCD_W + BIN_W;
    localparam logic [3:0] LAST_ITER = 4'(BIN_W - 1);

    conv_state_e      r_state;
    conv_state_e      w_state_nxt;
    logic [SH_W-1:0]  r_shift;      // {bcd, remaining binary bits}
    logic [SH_W-1:0]  w_shift_nxt;
    logic [SH_W-1:0]  w_step;
    logic [3:0]       r_iter;
    logic [3:0]       w_iter_nxt;
    logic             w_done;

    // One double-dabble iteration applied to the current shift register
    assign w_step = {dd_adjust(r_shift[SH_W-1:BIN_W]), r_shift[BIN_W-1:0]} << 1;

    // The final iteration's result is handed out combinationally so the
    // caller can latch it on the same edge that enters DONE
    assign o_bcd  = w_step[SH_W-1:BIN_W];
    assign o_done = w_done;
    assign o_busy = (r_state != IDLE);

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_iter  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_iter  <= w_iter_nxt;
        end
    end

    // Next-state, datapath and done-pulse decode
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_iter_nxt  = r_iter;
        w_done      = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_nxt = SHIFT;
                    w_shift_nxt = {{BCD_W{1'b0}}, i_bin};
                    w_iter_nxt  = 4'd0;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            SHIFT: begin
                w_shift_nxt = w_step;
                w_iter_nxt  = r_iter + 4'd1;
                if (r_iter == LAST_ITER) begin
                    w_state_nxt = DONE;
                    w_done      = 1'b1;
                end else begin
                    w_state_nxt = SHIFT;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/seg7_scan_timer.sv
// -----------------------------------------------------------------------------
// seg7_scan_timer
// Scan stage for a 3-digit 7-segment display. A prescaler divides the clock
// into DIV-cycle phases, the phase bus steps 00 -> 01 -> 10, and the BCD digit
// for the phase being shown is presented with an anti-ghosting blank strobe at
// the start of each phase. Values are converted to BCD sequentially and only
// become visible at a frame boundary (phase 10 -> 00).
//
// Parameters:
//   DIV    clock cycles per scan phase (>= 2)
//   BLANK  cycles at the start of each phase with o_blank high (< DIV)
//
// Ports:
//   i_clk    clock
//   i_rst    synchronous active-high reset
//   i_en     scan enable; low freezes prescaler/phase and forces blanking
//   i_value  binary value to display (clamped to 999)
//   i_load   one-cycle conversion request, ignored while busy
//   o_phase  scan phase bus (00 ones, 01 tens, 10 hundreds)
//   o_digit  BCD digit for o_phase
//   o_blank  segments off
//   o_busy   conversion in progress
//   o_ovf    sticky: last accepted value exceeded 999
// -----------------------------------------------------------------------------
module seg7_scan_timer
    import seg7_pkg::*;
#(
    parameter int DIV   = 50000,
    parameter int BLANK = 16
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [9:0] i_value,
    input  logic       i_load,
    output logic [1:0] o_phase,
    output logic [3:0] o_digit,
    output logic       o_blank,
    output logic       o_busy,
    output logic       o_ovf
);

    localparam int          PW        = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PCNT_MAX  = PW'(DIV - 1);
    localparam logic [PW-1:0] BLANK_CNT = PW'(BLANK);

    logic [PW-1:0]    r_pcnt;
    logic [PW-1:0]    w_pcnt_nxt;
    logic [1:0]       r_phase;
    logic [1:0]       w_phase_nxt;
    logic             r_blank;
    logic [3:0]       r_digit;
    logic [3:0]       w_digit_nxt;
    logic             r_ovf;
    logic [BCD_W-1:0] r_disp;
    logic [BCD_W-1:0] w_disp_nxt;
    logic [BCD_W-1:0] r_pending;
    logic             r_pend_valid;

    logic             w_tick;
    logic             w_commit;
    logic             w_accept;
    logic [BIN_W-1:0] w_bin;
    logic             w_conv_busy;
    logic             w_conv_done;
    logic [BCD_W-1:0] w_conv_bcd;

    assign w_tick   = i_en && (r_pcnt == PCNT_MAX);
    // A frame ends on the tick leaving the hundreds phase
    assign w_commit = w_tick && (r_phase == PH_D3) && r_pend_valid;
    assign w_accept = i_load && !w_conv_busy;
    assign w_bin    = (i_value > MAX_VALUE) ? MAX_VALUE : i_value;

    bin2bcd_seq u_conv (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (w_accept),
        .i_bin   (w_bin),
        .o_busy  (w_conv_busy),
        .o_done  (w_conv_done),
        .o_bcd   (w_conv_bcd)
    );

    // Prescaler, phase and display next-state; the digit follows the phase
    // and display contents that will be in effect after this edge
    always_comb begin
        w_pcnt_nxt  = r_pcnt;
        w_phase_nxt = r_phase;
        w_disp_nxt  = r_disp;
        w_digit_nxt = 4'd0;
        if (w_tick) begin
            w_pcnt_nxt  = {PW{1'b0}};
            w_phase_nxt = next_phase(r_phase);
        end else if (i_en) begin
            w_pcnt_nxt  = r_pcnt + PW'(1);
            w_phase_nxt = r_phase;
        end else begin
            w_pcnt_nxt  = r_pcnt;
            w_phase_nxt = r_phase;
        end
        if (w_commit) begin
            w_disp_nxt = r_pending;
        end else begin
            w_disp_nxt = r_disp;
        end
        case (w_phase_nxt)
            PH_D1:   w_digit_nxt = w_disp_nxt[3:0];
            PH_D2:   w_digit_nxt = w_disp_nxt[7:4];
            PH_D3:   w_digit_nxt = w_disp_nxt[11:8];
            default: w_digit_nxt = 4'd0;
        endcase
    end

    // Scan counters, registered outputs and the pending/display pipeline
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_pcnt       <= {PW{1'b0}};
            r_phase      <= PH_D1;
            r_blank      <= 1'b1;
            r_digit      <= 4'd0;
            r_ovf        <= 1'b0;
            r_disp       <= {BCD_W{1'b0}};
            r_pending    <= {BCD_W{1'b0}};
            r_pend_valid <= 1'b0;
        end else begin
            r_pcnt  <= w_pcnt_nxt;
            r_phase <= w_phase_nxt;
            r_blank <= (w_pcnt_nxt < BLANK_CNT);
            r_digit <= w_digit_nxt;
            r_disp  <= w_disp_nxt;
            if (w_accept) begin
                r_ovf <= (i_value > MAX_VALUE);
            end else begin
                r_ovf <= r_ovf;
            end
            // A result finishing on the commit edge stays pending: the old
            // pending value has just moved to the display
            if (w_conv_done) begin
                r_pending    <= w_conv_bcd;
                r_pend_valid <= 1'b1;
            end else if (w_commit) begin
                r_pending    <= r_pending;
                r_pend_valid <= 1'b0;
            end else begin
                r_pending    <= r_pending;
                r_pend_valid <= r_pend_valid;
            end
        end
    end

    assign o_phase = r_phase;
    assign o_digit = r_digit;
    assign o_blank = r_blank | ~i_en;   // enable low blanks immediately
    assign o_busy  = w_conv_busy;
    assign o_ovf   = r_ovf;

endmodule

// File: tb/tb_seg7_scan_timer.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_timer
// Self-checking bench for seg7_scan_timer with DIV=4, BLANK=1. A cycle model
// built from the block description predicts every output after each edge; the
// prediction is queued at the edge and compared at the following falling edge.
// A conversion table and hand-written sequences add end-result checks.
// -----------------------------------------------------------------------------
module tb_seg7_scan_timer;

    localparam int DIV_P   = 4;
    localparam int BLANK_P = 1;

    logic       clk;
    logic       i_rst;
    logic       i_en;
    logic [9:0] i_value;
    logic       i_load;
    logic [1:0] o_phase;
    logic [3:0] o_digit;
    logic       o_blank;
    logic       o_busy;
    logic       o_ovf;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] phase;
        logic [3:0] digit;
        logic       blank;
        logic       busy;
        logic       ovf;
    } exp_t;

    exp_t sb_q[$];

    typedef struct {
        logic [9:0] value;
        logic       ovf;
        logic [3:0] d0;
        logic [3:0] d1;
        logic [3:0] d2;
    } vec_t;

    vec_t tbl[7];

    // reference model state
    int          m_pcnt;
    int          m_phase;
    int          m_cnt;
    int          m_cval;
    logic        m_ovf;
    logic [11:0] m_disp;
    logic [11:0] m_pend;
    logic        m_pv;
    logic [3:0]  m_digit;
    logic        m_blank_r;

    seg7_scan_timer #(.DIV(DIV_P), .BLANK(BLANK_P)) dut (
        .i_clk   (clk),
        .i_rst   (i_rst),
        .i_en    (i_en),
        .i_value (i_value),
        .i_load  (i_load),
        .o_phase (o_phase),
        .o_digit (o_digit),
        .o_blank (o_blank),
        .o_busy  (o_busy),
        .o_ovf   (o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [11:0] to_bcd(input int v);
        logic [3:0] h;
        logic [3:0] t;
        logic [3:0] o;
        h = 4'(v / 100);
        t = 4'((v / 10) % 10);
        o = 4'(v % 10);
        return {h, t, o};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic rst, input logic en, input logic load, input logic [9:0] val);
        logic tick;
        logic commit;
        logic done;
        if (rst) begin
            m_pcnt  = 0;
            m_phase = 0;
            m_cnt   = 0;
            m_cval  = 0;
            m_ovf   = 1'b0;
            m_disp  = 12'h000;
            m_pend  = 12'h000;
            m_pv    = 1'b0;
            m_digit = 4'd0;
        end else begin
            tick   = en && (m_pcnt == DIV_P - 1);
            commit = tick && (m_phase == 2) && m_pv;
            done   = (m_cnt == 2);
            if (commit) m_disp = m_pend;
            if (done) begin
                m_pend = to_bcd(m_cval);
                m_pv   = 1'b1;
            end else if (commit) begin
                m_pv = 1'b0;
            end
            if (m_cnt != 0) begin
                m_cnt--;
            end else if (load) begin
                m_cnt  = 11;
                m_cval = (int'(val) > 999) ? 999 : int'(val);
                m_ovf  = (int'(val) > 999);
            end
            if (en) m_pcnt = tick ? 0 : m_pcnt + 1;
            if (tick) m_phase = (m_phase == 2) ? 0 : m_phase + 1;
            m_digit = m_disp[m_phase*4 +: 4];
        end
        m_blank_r = (m_pcnt < BLANK_P);
    endtask

    // one clock: drive, predict at the edge, compare on the falling edge
    task automatic step(input logic rst, input logic en, input logic load, input logic [9:0] val);
        exp_t e;
        i_rst   = rst;
        i_en    = en;
        i_load  = load;
        i_value = val;
        @(posedge clk);
        model_edge(rst, en, load, val);
        e.phase = 2'(m_phase);
        e.digit = m_digit;
        e.blank = m_blank_r | ~en;
        e.busy  = (m_cnt != 0);
        e.ovf   = m_ovf;
        sb_q.push_back(e);
        @(negedge clk);
        e = sb_q.pop_front();
        chk("cyc_phase", 32'(o_phase), 32'(e.phase));
        chk("cyc_digit", 32'(o_digit), 32'(e.digit));
        chk("cyc_blank", 32'(o_blank), 32'(e.blank));
        chk("cyc_busy",  32'(o_busy),  32'(e.busy));
        chk("cyc_ovf",   32'(o_ovf),   32'(e.ovf));
    endtask

    task automatic frame_chk(input int n, input logic [3:0] d0, input logic [3:0] d1,
                             input logic [3:0] d2, input string tag);
        logic [3:0] ex;
        for (int k = 0; k < n; k++) begin
            step(1'b0, 1'b1, 1'b0, 10'd0);
            ex = (m_phase == 0) ? d0 : ((m_phase == 1) ? d1 : d2);
            chk(tag, 32'(o_digit), 32'(ex));
        end
    endtask

    task automatic align(input int ph, input int pc);
        int n;
        n = 0;
        while (!(m_phase == ph && m_pcnt == pc && m_cnt == 0 && m_pv == 1'b0) && n < 60) begin
            step(1'b0, 1'b1, 1'b0, 10'd0);
            n++;
        end
        chk("align_bound", 32'(n < 60), 32'd1);
    endtask

    initial begin
        int  busy_cnt;
        int  sp;

        tbl[0] = '{10'd123,  1'b0, 4'd3, 4'd2, 4'd1};
        tbl[1] = '{10'd1000, 1'b1, 4'd9, 4'd9, 4'd9};
        tbl[2] = '{10'd7,    1'b0, 4'd7, 4'd0, 4'd0};
        tbl[3] = '{10'd999,  1'b0, 4'd9, 4'd9, 4'd9};
        tbl[4] = '{10'd1023, 1'b1, 4'd9, 4'd9, 4'd9};
        tbl[5] = '{10'd0,    1'b0, 4'd0, 4'd0, 4'd0};
        tbl[6] = '{10'd580,  1'b0, 4'd0, 4'd8, 4'd5};

        i_rst = 1'b1; i_en = 1'b0; i_load = 1'b0; i_value = 10'd0;
        @(negedge clk);

        // reset
        step(1'b1, 1'b0, 1'b0, 10'd0);
        step(1'b1, 1'b1, 1'b1, 10'd555);
        chk("rst_phase", 32'(o_phase), 32'd0);
        chk("rst_digit", 32'(o_digit), 32'd0);
        chk("rst_blank", 32'(o_blank), 32'd1);
        chk("rst_busy",  32'(o_busy),  32'd0);
        chk("rst_ovf",   32'(o_ovf),   32'd0);

        // scan sequence: each phase held DIV cycles, blank on its first cycle
        for (int j = 1; j <= 24; j++) begin
            step(1'b0, 1'b1, 1'b0, 10'd0);
            chk("scan_phase", 32'(o_phase), 32'((j / 4) % 3));
            chk("scan_blank", 32'(o_blank), 32'((j % 4) == 0));
        end

        // conversion table
        for (int v = 0; v < 7; v++) begin
            busy_cnt = 0;
            step(1'b0, 1'b1, 1'b1, tbl[v].value);
            if (o_busy === 1'b1) busy_cnt++;
            for (int k = 0; k < 13; k++) begin
                step(1'b0, 1'b1, 1'b0, 10'd0);
                if (o_busy === 1'b1) busy_cnt++;
            end
            chk("tbl_busy_len", 32'(busy_cnt), 32'd11);
            chk("tbl_ovf", 32'(o_ovf), 32'(tbl[v].ovf));
            for (int k = 0; k < 24; k++) step(1'b0, 1'b1, 1'b0, 10'd0);
            frame_chk(12, tbl[v].d0, tbl[v].d1, tbl[v].d2, "tbl_digit");
        end

        // LOAD while busy is ignored
        step(1'b0, 1'b1, 1'b1, 10'd456);
        step(1'b0, 1'b1, 1'b0, 10'd0);
        step(1'b0, 1'b1, 1'b0, 10'd0);
        step(1'b0, 1'b1, 1'b1, 10'd789);
        for (int k = 0; k < 40; k++) step(1'b0, 1'b1, 1'b0, 10'd0);
        frame_chk(12, 4'd6, 4'd5, 4'd4, "busy_load_digit");

        // frame integrity: conversion finishes during phase 01
        align(2, 0);
        step(1'b0, 1'b1, 1'b1, 10'd321);
        frame_chk(14, 4'd6, 4'd5, 4'd4, "frame_old_digit");
        frame_chk(12, 4'd1, 4'd2, 4'd3, "frame_new_digit");

        // DONE on the same edge as the commit: old pending shows, new stays pending
        align(0, 1);
        step(1'b0, 1'b1, 1'b1, 10'd111);
        for (int k = 0; k < 11; k++) step(1'b0, 1'b1, 1'b0, 10'd0);
        step(1'b0, 1'b1, 1'b1, 10'd222);
        frame_chk(9, 4'd1, 4'd2, 4'd3, "coinc_pre_digit");
        frame_chk(12, 4'd1, 4'd1, 4'd1, "coinc_first_digit");
        frame_chk(12, 4'd2, 4'd2, 4'd2, "coinc_second_digit");

        // EN low mid-phase freezes phase and forces blanking
        step(1'b0, 1'b1, 1'b0, 10'd0);
        step(1'b0, 1'b1, 1'b0, 10'd0);
        sp = m_phase;
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b0, 1'b0, 10'd0);
            chk("en_low_phase", 32'(o_phase), 32'(sp));
            chk("en_low_blank", 32'(o_blank), 32'd1);
        end
        for (int k = 0; k < 6; k++) step(1'b0, 1'b1, 1'b0, 10'd0);

        // reset during SHIFT discards the conversion
        step(1'b0, 1'b1, 1'b1, 10'd888);
        for (int k = 0; k < 4; k++) step(1'b0, 1'b1, 1'b0, 10'd0);
        step(1'b1, 1'b1, 1'b0, 10'd0);
        chk("rst_shift_busy", 32'(o_busy), 32'd0);
        frame_chk(36, 4'd0, 4'd0, 4'd0, "rst_shift_digit");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_timer.md
# seg7_scan_timer

Upstream scan stage for the 3-digit 7-segment display. It divides the system clock into a digit-scan tick and drives the 2-bit phase bus (00, 01, 10) that the digit switcher decodes into D1/D2/D3. It also converts a binary value (0-999) to BCD with a sequential converter. For each phase it presents the matching BCD digit plus a blanking strobe that suppresses ghosting. New values take effect only at frame boundaries, so a frame never shows a mix of old and new digits.

## Interface
Parameters:
- DIV, 50000: system-clock cycles per scan phase; legal range is 2 or more.
- BLANK, 16: cycles at the start of each phase during which BLANK is high. Must satisfy BLANK < DIV.

Ports:
- CLK  in  1: single clock for the block.
- RST  in  1: synchronous, active-high reset.
- EN  in  1: scan enable. While low, the prescaler and PHASE hold and BLANK is forced to 1.
- VALUE  in  10: binary value to display.
- LOAD  in  1: one-cycle request to convert VALUE.
- PHASE  out  2: scan phase bus to the digit switcher (00→D1, 01→D2, 10→D3). Value 11 never occurs.
- DIGIT  out  4: BCD digit for the current phase (00 ones, 01 tens, 10 hundreds).
- BLANK  out  1: high means segments off.
- BUSY  out  1: conversion in progress.
- OVF  out  1: sticky; set when the last accepted VALUE exceeded 999.

## Operation
- **Prescaler.** Counter `pcnt` counts 0 to DIV-1 while EN=1. The tick fires on the cycle `pcnt` equals DIV-1; `pcnt` then wraps to 0.
- **Phase advance.** Each tick advances PHASE in the order 00→01→10→00.
- **Blanking.** BLANK=1 whenever `pcnt` < BLANK or EN=0; otherwise BLANK=0.
- **Converter FSM.** States are IDLE, SHIFT, DONE.
  - IDLE → SHIFT when LOAD=1. VALUE is captured on that cycle. If VALUE > 999, the captured value is clamped to 999 and OVF is set; otherwise OVF is cleared.
  - SHIFT runs 10 double-dabble iterations, one per cycle. Before each shift, add 3 to any BCD nibble that is ≥5.
  - SHIFT → DONE after the 10th iteration. The result is latched into `pending` (12 bits) and the `pend_valid` flag is set.
  - DONE → IDLE on the next cycle.
  - BUSY=1 in the SHIFT and DONE states.
  - LOAD is ignored while BUSY=1.
- **Frame commit.** On a tick that moves PHASE from 10 to 00 with `pend_valid`=1, copy `pending` to `disp` and clear `pend_valid`.
  - If a new conversion completes before the commit, it overwrites `pending`; the last one wins.
  - If the commit and DONE occur on the same cycle, commit the old `pending`, then latch the new result, leaving `pend_valid`=1.
- **Digit output.** DIGIT is registered and shows the `disp` nibble selected by the next value of PHASE. PHASE and DIGIT therefore change on the same edge.

## Timing
- **Reset values** (all apply on the first edge with RST=1):
  - Outputs: PHASE=00, DIGIT=0, BLANK=1, BUSY=0, OVF=0.
  - Internal: `pcnt`=0, `disp`=000, `pending`=000, `pend_valid`=0, FSM in IDLE.
  - RST aborts a conversion in progress; the partial result is discarded.
  - RST has priority over EN and LOAD.
- **Conversion timing:**
  - LOAD sampled at edge t.
  - BUSY=1 from t+1 through t+11.
  - `pend_valid`=1 from t+11.
  - The next LOAD is accepted at t+12.
- **Commit latency:** from `pend_valid` to display is at most 3·DIV cycles (one full frame).
- **Phase length:** each phase lasts exactly DIV cycles while EN=1. With BLANK=0, BLANK never asserts while EN=1.
- **EN behaviour:** deasserting EN freezes `pcnt` and PHASE. Reasserting EN resumes from the held count; the prescaler does not restart.

## Structure
- **Package `seg7_pkg`:**
  - Constants PH_D1=2'b00, PH_D2=2'b01, PH_D3=2'b10.
  - NUM_DIGITS=3, MAX_VALUE=10'd999.
  - The converter state enum {IDLE, SHIFT, DONE}.
- **Sub-module `bin2bcd_seq`:**
  - Contains the 10-bit to 3×BCD double-dabble FSM.
  - Ports: CLK, RST, START, BIN[9:0], BUSY, DONE, BCD[11:0].
- **Top level:** holds the prescaler, phase counter, blanking logic, `pending`/`disp` registers and the DIGIT mux.

## Test plan
- **Scan sequence.** RST for 2 cycles, then EN=1 with DIV=4, BLANK=1. Required: PHASE runs 00,01,10,00 with each value held 4 cycles, and BLANK=1 only on the first cycle of each phase.
- **Normal conversion.** LOAD with VALUE=123. Required: BUSY=1 for 11 cycles, OVF=0. After the next 10→00 wrap, DIGIT reads 3 at PHASE 00, 2 at 01 and 1 at 10.
- **Overflow.** LOAD with VALUE=1000. Required: OVF=1 and digits 9,9,9. A following LOAD with VALUE=7 clears OVF and gives digits 7,0,0.
- **LOAD while busy.** LOAD VALUE=456, then LOAD VALUE=789 three cycles later. Required: the second LOAD is ignored and the display shows 6,5,4.
- **Frame integrity.** LOAD completes while PHASE=01. Required: D2 and D3 still show the old digits for the rest of that frame, and new digits appear from the next PHASE=00.
- **EN low / reset mid-operation.** Hold EN=0 mid-phase. Required: PHASE and `pcnt` freeze and BLANK=1. Assert RST during SHIFT. Required: BUSY=0 next cycle, display stays at 0,0,0, and `pend_valid` is never set.
